// File: rtl/sorter_pkg.sv
// Shared sizing defaults and FSM encoding for the sorted-sequence output path.
package sorter_pkg;
  localparam int SORT_DW = 8;
  localparam int SORT_N  = 4;
  localparam int SORT_IW = $clog2(SORT_N);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/seq_word_buf.sv
// Single N-element word buffer: loads a whole word, reads back one element by index.
module seq_word_buf #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [N*DW-1:0]   d_i,
  input  logic [IW-1:0]     rd_idx_i,
  output logic [DW-1:0]     rd_data_o
);
  logic [N-1:0][DW-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    buf_q <= '0;
    else if (ld_i) buf_q <= d_i;
  end

  assign rd_data_o = buf_q[rd_idx_i];
endmodule

// File: rtl/sorted_seq_serializer.sv
// Serializes one sorted N-element word into an element stream, minimum first.
// Optional input ordering check: define SORTED_SEQ_ORDER_CHECK_EN.
module sorted_seq_serializer
  import sorter_pkg::*;
#(
  parameter int DW = SORT_DW,
  parameter int N  = SORT_N,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            order_err
);
  state_e          state_q;
  logic            out_valid_q, out_last_q;
  logic [DW-1:0]   out_data_q, rd_data;
  logic [IW-1:0]   out_idx_q, idx_d;
  logic            accept, hs;

  assign hs       = out_valid_q & out_ready;
  assign in_ready = (state_q == ST_IDLE) | (hs & out_last_q);
  assign accept   = in_valid & in_ready;
  assign idx_d    = out_idx_q + IW'(1);

  // Buffer read port already points at the next element so the advance is one register stage.
  seq_word_buf #(.DW(DW), .N(N), .IW(IW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (accept),
    .d_i      (in_data),
    .rd_idx_i (idx_d),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q     <= ST_SHIFT;
          out_valid_q <= 1'b1;
          out_data_q  <= in_data[DW-1:0];
          out_idx_q   <= '0;
          out_last_q  <= 1'b0;
        end
        ST_SHIFT: if (hs) begin
          if (!out_last_q) begin
            out_idx_q  <= idx_d;
            out_data_q <= rd_data;
            out_last_q <= (idx_d == IW'(N-1));
          end else if (accept) begin
            // New word lands on the last beat: element 0 follows with no bubble.
            out_data_q <= in_data[DW-1:0];
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

`ifdef SORTED_SEQ_ORDER_CHECK_EN
  logic bad_order, order_err_q;

  always_comb begin
    bad_order = 1'b0;
    for (int i = 1; i < N; i++)
      if (in_data[i*DW +: DW] < in_data[(i-1)*DW +: DW]) bad_order = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     order_err_q <= 1'b0;
    else if (accept && bad_order)   order_err_q <= 1'b1;
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif
endmodule
